// File: rtl/mig_app_bridge_if.sv
// Request/response and MIG native app-port signal bundle for mig_app_bridge.
// slave = bridge view; master = the upstream requester and controller side.
interface mig_app_bridge_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_data;
  logic [DATA_WIDTH/8-1:0]   req_mask;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_data;
  logic [ADDR_WIDTH-1:0]     app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  logic [DATA_WIDTH-1:0]     app_wdf_data;
  logic [DATA_WIDTH/8-1:0]   app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;
  logic [DATA_WIDTH-1:0]     app_rd_data;
  logic                      app_rd_data_valid;

  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_mask, rsp_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    output req_ready, rsp_valid, rsp_data, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport master (
    output req_valid, req_write, req_addr, req_data, req_mask, rsp_ready,
           app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
    input  req_ready, rsp_valid, rsp_data, app_addr, app_cmd, app_en,
           app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/mig_app_bridge.sv
// Front end for the MIG native app interface: independent cmd/wdf retirement and a
// credit-protected in-order read FIFO. Define MIG_BRIDGE_PERF_EN to build the stall counters.
module mig_app_bridge #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int RD_DEPTH   = 16
) (
  input  logic                        clk_100,
  input  logic                        reset_n,
  mig_app_bridge_if.slave             bus,
  output logic [$clog2(RD_DEPTH):0]   reads_outstanding,
  output logic                        overflow,
  output logic [31:0]                 cmd_stall_cycles,
  output logic [31:0]                 wdf_stall_cycles
);
  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_DEPTH = CW'(RD_DEPTH);

  typedef enum logic [2:0] {
    CMD_WRITE = 3'b000,
    CMD_READ  = 3'b001
  } app_cmd_e;

  logic                      r_app_en;
  app_cmd_e                  r_app_cmd;
  logic [ADDR_WIDTH-1:0]     r_app_addr;
  logic                      r_wren;
  logic [DATA_WIDTH-1:0]     r_wdf_data;
  logic [DATA_WIDTH/8-1:0]   r_wdf_mask;
  logic [CW-1:0]             r_credits;
  logic [CW-1:0]             r_outstanding;
  logic                      r_overflow;
  logic [PW:0]               r_wr_ptr;
  logic [PW:0]               r_rd_ptr;
  logic [DATA_WIDTH-1:0]     r_mem [RD_DEPTH];

  logic w_cmd_free, w_wdf_free, w_req_ready, w_accept, w_rd_acc;
  logic w_empty, w_full, w_push_ok, w_pop, w_ret;

  assign w_cmd_free  = ~r_app_en | bus.app_rdy;
  assign w_wdf_free  = ~r_wren | bus.app_wdf_rdy;
  assign w_req_ready = w_cmd_free & w_wdf_free & (r_credits != '0);
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_rd_acc    = w_accept & ~bus.req_write;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_push_ok = bus.app_rd_data_valid & ~w_full;
  assign w_pop     = ~w_empty & bus.rsp_ready;
  // A return with nothing outstanding is spurious; keep the counter from underflowing.
  assign w_ret     = bus.app_rd_data_valid & (r_outstanding != '0);

  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      r_app_en   <= 1'b0;
      r_app_cmd  <= CMD_WRITE;
      r_app_addr <= '0;
      r_wren     <= 1'b0;
      r_wdf_data <= '0;
      r_wdf_mask <= '0;
    end else begin
      if (w_accept) begin
        r_app_en   <= 1'b1;
        r_app_cmd  <= bus.req_write ? CMD_WRITE : CMD_READ;
        r_app_addr <= bus.req_addr;
      end else if (bus.app_rdy) begin
        r_app_en <= 1'b0;
      end
      if (w_accept && bus.req_write) begin
        r_wren     <= 1'b1;
        r_wdf_data <= bus.req_data;
        r_wdf_mask <= bus.req_mask;
      end else if (bus.app_wdf_rdy) begin
        r_wren <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      r_credits     <= C_DEPTH;
      r_outstanding <= '0;
      r_overflow    <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      case ({w_rd_acc, w_ret})
        2'b10:   r_outstanding <= r_outstanding + C_ONE;
        2'b01:   r_outstanding <= r_outstanding - C_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
      case ({w_rd_acc, w_pop})
        2'b10:   r_credits <= r_credits - C_ONE;
        2'b01:   r_credits <= r_credits + C_ONE;
        default: r_credits <= r_credits;
      endcase
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
      if (bus.app_rd_data_valid && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_100) begin
    if (w_push_ok) r_mem[r_wr_ptr[PW-1:0]] <= bus.app_rd_data;
  end

`ifdef MIG_BRIDGE_PERF_EN
  logic [31:0] r_cmd_stall;
  logic [31:0] r_wdf_stall;

  always_ff @(posedge clk_100) begin
    if (!reset_n) begin
      r_cmd_stall <= '0;
      r_wdf_stall <= '0;
    end else begin
      if (r_app_en && !bus.app_rdy && (r_cmd_stall != '1)) r_cmd_stall <= r_cmd_stall + 32'd1;
      if (r_wren && !bus.app_wdf_rdy && (r_wdf_stall != '1)) r_wdf_stall <= r_wdf_stall + 32'd1;
    end
  end

  assign cmd_stall_cycles = r_cmd_stall;
  assign wdf_stall_cycles = r_wdf_stall;
`else
  assign cmd_stall_cycles = '0;
  assign wdf_stall_cycles = '0;
`endif

  assign bus.req_ready    = w_req_ready;
  assign bus.rsp_valid    = ~w_empty;
  assign bus.rsp_data     = r_mem[r_rd_ptr[PW-1:0]];
  assign bus.app_en       = r_app_en;
  assign bus.app_cmd      = r_app_cmd;
  assign bus.app_addr     = r_app_addr;
  assign bus.app_wdf_wren = r_wren;
  assign bus.app_wdf_end  = r_wren;
  assign bus.app_wdf_data = r_wdf_data;
  assign bus.app_wdf_mask = r_wdf_mask;
  assign reads_outstanding = r_outstanding;
  assign overflow          = r_overflow;
endmodule

// File: tb/tb_mig_app_bridge.sv
// Self-checking bench for mig_app_bridge: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mig_app_bridge;
  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int MW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk_100 = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_100 = ~clk_100;

  mig_app_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  logic [CW-1:0] reads_outstanding;
  logic          overflow;
  logic [31:0]   cmd_stall_cycles;
  logic [31:0]   wdf_stall_cycles;

  mig_app_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_DEPTH(DEPTH)) dut (
    .clk_100           (clk_100),
    .reset_n           (reset_n),
    .bus               (bus),
    .reads_outstanding (reads_outstanding),
    .overflow          (overflow),
    .cmd_stall_cycles  (cmd_stall_cycles),
    .wdf_stall_cycles  (wdf_stall_cycles)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Reference model: one pending command, one pending data beat, a response queue.
  bit              m_en, m_wren, m_ovf;
  logic [AW-1:0]   m_addr;
  logic [2:0]      m_cmd;
  logic [DW-1:0]   m_data;
  logic [MW-1:0]   m_mask;
  int              m_out;
  logic [DW-1:0]   m_q[$];
  longint          m_cs, m_ws;

  function automatic void model_reset();
    m_en = 0; m_wren = 0; m_ovf = 0; m_out = 0; m_cs = 0; m_ws = 0;
    m_q.delete();
  endfunction

  function automatic bit m_ready();
    int credits;
    credits = DEPTH - m_out - m_q.size();
    return (!m_en || bus.app_rdy) && (!m_wren || bus.app_wdf_rdy) && (credits > 0);
  endfunction

  function automatic void model_check();
    chk("req_ready", bus.req_ready, m_ready());
    chk("rsp_valid", bus.rsp_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk("rsp_data", bus.rsp_data, m_q[0]);
    chk("app_en", bus.app_en, m_en);
    if (m_en) begin
      chk("app_addr", bus.app_addr, m_addr);
      chk("app_cmd", bus.app_cmd, m_cmd);
    end
    chk("app_wdf_wren", bus.app_wdf_wren, m_wren);
    chk("app_wdf_end", bus.app_wdf_end, m_wren);
    if (m_wren) begin
      chk("app_wdf_data", bus.app_wdf_data, m_data);
      chk("app_wdf_mask", bus.app_wdf_mask, m_mask);
    end
    chk("reads_outstanding", reads_outstanding, m_out);
    chk("overflow", overflow, m_ovf);
`ifdef MIG_BRIDGE_PERF_EN
    chk("cmd_stall_cycles", cmd_stall_cycles, m_cs);
    chk("wdf_stall_cycles", wdf_stall_cycles, m_ws);
`else
    chk("cmd_stall_cycles", cmd_stall_cycles, 0);
    chk("wdf_stall_cycles", wdf_stall_cycles, 0);
`endif
  endfunction

  // Advance the model by one edge using only the inputs currently driven.
  function automatic void model_step();
    bit acc, pop, was_full;
    acc      = bus.req_valid && m_ready();
    pop      = (m_q.size() != 0) && bus.rsp_ready;
    was_full = (m_q.size() == DEPTH);
    if (m_en && !bus.app_rdy) m_cs++;
    if (m_wren && !bus.app_wdf_rdy) m_ws++;
    if (bus.app_rd_data_valid && m_out > 0) m_out--;
    if (acc && !bus.req_write) m_out++;
    if (pop) void'(m_q.pop_front());
    if (bus.app_rd_data_valid) begin
      if (was_full) m_ovf = 1;
      else m_q.push_back(bus.app_rd_data);
    end
    if (acc) begin
      m_en   = 1;
      m_addr = bus.req_addr;
      m_cmd  = bus.req_write ? 3'b000 : 3'b001;
    end else if (bus.app_rdy) m_en = 0;
    if (acc && bus.req_write) begin
      m_wren = 1;
      m_data = bus.req_data;
      m_mask = bus.req_mask;
    end else if (bus.app_wdf_rdy) m_wren = 0;
  endfunction

  task automatic set_idle();
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_mask = '0; bus.rsp_ready = 0;
    bus.app_rdy = 1; bus.app_wdf_rdy = 1;
    bus.app_rd_data_valid = 0; bus.app_rd_data = '0;
  endtask

  // Inputs change at posedge+1; checks at posedge+2; returns at the next posedge+1.
  task automatic cycle();
    #1;
    model_check();
    model_step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 0;
    repeat (2) @(posedge clk_100);
    #1;
    reset_n = 1;
    model_reset();
  endtask

  task automatic fill_fifo(input logic [DW-1:0] base);
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = AW'(32'h100 + i);
      bus.rsp_ready = 0;
      bus.app_rd_data_valid = (i >= 2);
      bus.app_rd_data = base + DW'(i - 2);
      cycle();
    end
    bus.req_valid = 0;
    for (int j = 14; j < 16; j++) begin
      bus.app_rd_data_valid = 1;
      bus.app_rd_data = base + DW'(j);
      cycle();
    end
    bus.app_rd_data_valid = 0;
  endtask

  typedef struct {
    bit            vld;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            ardy;
    bit            wrdy;
    bit            x_ready;
    bit            x_en;
    bit            x_wren;
    logic [AW-1:0] x_addr;
    logic [2:0]    x_cmd;
    logic [DW-1:0] x_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d1, d2, d3;
    int en_cnt;
    d1 = 128'hdeadbeef_00112233_44556677_8899babe;
    d2 = 128'h22222222_12345678_9abcdef0_0f0f0f0f;
    d3 = 128'h33333333_33333333_33333333_33333333;
    //            vld wr addr    data ardy wrdy rdy en wren x_addr  cmd     x_data
    tbl[0] = '{1, 1, 28'h10, d1, 1, 1, 1, 1, 1, 28'h10, 3'b000, d1};
    tbl[1] = '{0, 0, 28'h0,  '0, 1, 1, 1, 0, 0, 28'h0,  3'b000, '0};
    tbl[2] = '{1, 1, 28'h20, d2, 0, 1, 1, 1, 1, 28'h20, 3'b000, d2};
    tbl[3] = '{0, 0, 28'h0,  '0, 0, 1, 0, 1, 0, 28'h20, 3'b000, d2};
    tbl[4] = '{1, 1, 28'h30, d3, 0, 1, 0, 1, 0, 28'h20, 3'b000, d2};
    tbl[5] = '{1, 1, 28'h30, d3, 0, 1, 0, 1, 0, 28'h20, 3'b000, d2};
    tbl[6] = '{1, 1, 28'h30, d3, 0, 1, 0, 1, 0, 28'h20, 3'b000, d2};
    tbl[7] = '{1, 1, 28'h30, d3, 0, 1, 0, 1, 0, 28'h20, 3'b000, d2};
    tbl[8] = '{0, 0, 28'h0,  '0, 1, 1, 1, 0, 0, 28'h0,  3'b000, '0};
    tbl[9] = '{0, 0, 28'h0,  '0, 1, 1, 1, 0, 0, 28'h0,  3'b000, '0};

    do_reset();
    chk("rst_app_en", bus.app_en, 0);
    chk("rst_wren", bus.app_wdf_wren, 0);
    chk("rst_app_cmd", bus.app_cmd, 0);
    chk("rst_app_addr", bus.app_addr, 0);
    chk("rst_wdf_data", bus.app_wdf_data, 0);
    chk("rst_wdf_mask", bus.app_wdf_mask, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_outstanding", reads_outstanding, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cmd_stall", cmd_stall_cycles, 0);
    chk("rst_wdf_stall", wdf_stall_cycles, 0);
    chk("rst_req_ready", bus.req_ready, 1);

    // Single write, then a write whose command is held while its data beat retires.
    for (int i = 0; i < 10; i++) begin
      bus.req_valid = tbl[i].vld; bus.req_write = tbl[i].wr;
      bus.req_addr = tbl[i].addr; bus.req_data = tbl[i].data; bus.req_mask = '1;
      bus.app_rdy = tbl[i].ardy; bus.app_wdf_rdy = tbl[i].wrdy;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), bus.req_ready, tbl[i].x_ready);
      cycle();
      chk($sformatf("tbl%0d_app_en", i), bus.app_en, tbl[i].x_en);
      chk($sformatf("tbl%0d_wren", i), bus.app_wdf_wren, tbl[i].x_wren);
      chk($sformatf("tbl%0d_wdf_end", i), bus.app_wdf_end, tbl[i].x_wren);
      if (tbl[i].x_en) begin
        chk($sformatf("tbl%0d_addr", i), bus.app_addr, tbl[i].x_addr);
        chk($sformatf("tbl%0d_cmd", i), bus.app_cmd, tbl[i].x_cmd);
      end
      if (tbl[i].x_wren) chk($sformatf("tbl%0d_data", i), bus.app_wdf_data, tbl[i].x_data);
    end

    // 16 back-to-back writes with both ports ready.
    set_idle();
    en_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      bus.req_valid = 1; bus.req_write = 1; bus.req_addr = AW'(i);
      bus.req_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.req_mask = MW'($urandom());
      #1;
      chk("b2b_req_ready", bus.req_ready, 1);
      cycle();
      en_cnt += int'(bus.app_en);
    end
    set_idle();
    cycle();
    chk("b2b_en_count", en_cnt, 16);
    chk("b2b_en_low", bus.app_en, 0);

    // Credits exhausted by 16 reads, then in-order drain.
    fill_fifo(128'd1000);
    bus.req_valid = 1; bus.req_write = 0;
    #1;
    chk("credit_block", bus.req_ready, 0);
    cycle();
    bus.req_valid = 0; bus.rsp_ready = 1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("rsp_order", bus.rsp_data, 128'd1000 + DW'(k));
      cycle();
    end
    bus.rsp_ready = 0;
    #1;
    chk("ready_restored", bus.req_ready, 1);
    chk("drained", bus.rsp_valid, 0);

    // Read accept, push and pop on the same edge.
    set_idle();
    bus.req_valid = 1; bus.req_write = 0;
    cycle(); cycle();
    bus.req_valid = 0; bus.app_rd_data_valid = 1; bus.app_rd_data = 128'hA1;
    cycle();
    bus.req_valid = 1; bus.app_rd_data = 128'hA2; bus.rsp_ready = 1;
    #1;
    chk("same_pre_outstanding", reads_outstanding, 1);
    chk("same_pre_head", bus.rsp_data, 128'hA1);
    cycle();
    chk("same_post_outstanding", reads_outstanding, 1);
    chk("same_post_head", bus.rsp_data, 128'hA2);
    chk("same_post_valid", bus.rsp_valid, 1);
    bus.req_valid = 0; bus.app_rd_data = 128'hA3;
    cycle();
    chk("same_next_head", bus.rsp_data, 128'hA3);
    bus.app_rd_data_valid = 0;
    cycle();
    chk("same_empty", bus.rsp_valid, 0);
    chk("same_outstanding_zero", reads_outstanding, 0);

    // Spurious return into a full FIFO.
    set_idle();
    fill_fifo(128'd5000);
    bus.app_rd_data_valid = 1; bus.app_rd_data = 128'hBAD;
    cycle();
    bus.app_rd_data_valid = 0;
    chk("ovf_set", overflow, 1);
    chk("ovf_head_kept", bus.rsp_data, 128'd5000);
    repeat (3) cycle();
    bus.rsp_ready = 1;
    repeat (16) cycle();
    chk("ovf_sticky", overflow, 1);
    do_reset();
    chk("ovf_cleared", overflow, 0);

    // Stall counters: command held 7 cycles, then data held 3 cycles.
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 28'h40; bus.app_rdy = 0;
    cycle();
    bus.req_valid = 0;
    repeat (7) cycle();
    bus.app_rdy = 1;
    cycle();
    bus.req_valid = 1; bus.req_addr = 28'h44; bus.app_wdf_rdy = 0;
    cycle();
    bus.req_valid = 0;
    repeat (3) cycle();
    bus.app_wdf_rdy = 1;
    cycle();
`ifdef MIG_BRIDGE_PERF_EN
    chk("perf_cmd_stall", cmd_stall_cycles, 7);
    chk("perf_wdf_stall", wdf_stall_cycles, 3);
`else
    chk("perf_cmd_tied", cmd_stall_cycles, 0);
    chk("perf_wdf_tied", wdf_stall_cycles, 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bus.req_valid = ($urandom() % 4) != 0;
      bus.req_write = ($urandom() % 2) != 0;
      bus.req_addr  = AW'($urandom());
      bus.req_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.req_mask  = MW'($urandom());
      bus.app_rdy     = ($urandom() % 4) != 0;
      bus.app_wdf_rdy = ($urandom() % 4) != 0;
      bus.rsp_ready   = ($urandom() % 3) != 0;
      bus.app_rd_data_valid = (m_out > 0) && (($urandom() % 2) != 0);
      bus.app_rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      cycle();
    end
    set_idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mig_app_bridge.md
# mig_app_bridge

Request/response front end placed directly upstream of the DDR3 controller's native app interface. It accepts one request per cycle on a single valid/ready stream and drives the MIG command port (`app_en`/`app_rdy`) and write-data port (`app_wdf_wren`/`app_wdf_rdy`) independently, so a stall on one port never duplicates or drops a beat on the other. Read data arrives from the controller with no backpressure; the block buffers it in a credit-protected FIFO and returns it in order on a valid/ready response stream.

## Interface
- ADDR_WIDTH, 28, app address width
- DATA_WIDTH, 128, app data width; mask width is DATA_WIDTH/8
- RD_DEPTH, 16, read FIFO depth; power of two, ≥2
- clk_100  in  1  clock; the controller's ui_clk
- reset_n  in  1  synchronous, active-low reset; sampled on clk_100
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  app address, passed through unchanged
- req_data, req_mask  in  DATA_WIDTH, DATA_WIDTH/8  write payload; ignored for reads
- rsp_valid / rsp_ready  out / in  1 / 1  read-response handshake
- rsp_data  out  DATA_WIDTH  read data, in request order
- app_addr, app_cmd, app_en  out  ADDR_WIDTH, 3, 1  MIG command port; cmd 000 = write, 001 = read
- app_rdy  in  1  MIG command ready
- app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end  out  DATA_WIDTH, DATA_WIDTH/8, 1, 1  MIG write-data port
- app_wdf_rdy  in  1  MIG write-data ready
- app_rd_data, app_rd_data_valid  in  DATA_WIDTH, 1  MIG read return
- reads_outstanding  out  $clog2(RD_DEPTH)+1  reads issued whose data has not yet returned
- overflow  out  1  sticky; set by a push into a full FIFO
- cmd_stall_cycles, wdf_stall_cycles  out  32, 32  performance counters (see Configuration)

## Operation
- Reset values: app_en=0, app_wdf_wren=0, app_cmd=0, app_addr=0, app_wdf_data=0, app_wdf_mask=0, rsp_valid=0, reads_outstanding=0, overflow=0, both counters=0. FIFO is empty and credits are set to RD_DEPTH.
- `cmd_free = ~app_en | app_rdy`. `wdf_free = ~app_wdf_wren | app_wdf_rdy`.
- `req_ready = cmd_free & wdf_free & (credits != 0)`. This is combinational on app_rdy and app_wdf_rdy. Writes are also blocked when credits reach 0, which keeps ordering simple.
- On accept:
  - app_en←1; app_cmd and app_addr are registered.
  - If the request is a write: app_wdf_wren←1; data and mask are registered.
  - If the request is a read: credits decrement and reads_outstanding increments.
- Without a new accept:
  - app_en clears on app_en & app_rdy.
  - app_wdf_wren clears on app_wdf_wren & app_wdf_rdy.
  - Each port is retired independently; a held command never re-presents data that has already been taken, and vice versa.
- app_wdf_end = app_wdf_wren; each command carries one beat.
- app_rd_data_valid pushes app_rd_data into the FIFO and decrements reads_outstanding. A push and a read accept in the same cycle leave reads_outstanding unchanged.
- rsp_valid = FIFO non-empty, and rsp_data is the head entry. A pop (rsp_valid & rsp_ready) increments credits.
- Credits always equal RD_DEPTH − reads_outstanding − FIFO occupancy. A simultaneous read accept and pop leaves credits unchanged.
- Overflow: a push while the FIFO is full drops the data and sets overflow, which stays set until reset.
- Reset mid-operation discards all pending commands, outstanding reads and buffered data. The controller is reset from the same source.

## Timing
- Request accepted at edge N → app_en / app_wdf_wren high from N+1.
- Sustained throughput is one request per cycle while app_rdy = app_wdf_rdy = 1.
- app_rd_data_valid at edge N → rsp_valid high from N+1 when the FIFO was empty (registered FIFO read).
- Sustained throughput is one response per cycle with rsp_ready = 1.
- FIFO pointers wrap modulo RD_DEPTH. Full and empty are distinguished by an extra pointer bit.
- The stall counters saturate at 32'hFFFFFFFF; they do not wrap.

## Configuration
- `MIG_BRIDGE_PERF_EN` defined:
  - cmd_stall_cycles counts cycles with app_en & ~app_rdy.
  - wdf_stall_cycles counts cycles with app_wdf_wren & ~app_wdf_rdy.
  - Both clear on reset.
- Not defined: both counter ports are present and tied to 0, and no counter logic is built.

## Test plan
- Single write to addr 0x10 with data 0xdeadbeef…babe, both ports ready → app_en and app_wdf_wren high for exactly 1 cycle with matching addr/data, app_cmd=000, app_wdf_end=1.
- 16 back-to-back writes, both ready → 16 consecutive app_en cycles, req_ready held at 1 throughout.
- Write with app_rdy=0 for 5 cycles and app_wdf_rdy=1 → wdf beat retires after 1 cycle, command held 5 cycles, req_ready=0 until the command retires, and no duplicate data beat.
- 16 reads with rsp_ready=0 and data returned by the model → req_ready=0 after the 16th accept (credits=0); raising rsp_ready yields 16 in-order responses and req_ready returns high.
- Read accept, push and pop in the same cycle → credits and reads_outstanding checked constant, and data ordering preserved.
- Forced app_rd_data_valid with no outstanding read into a full FIFO → overflow=1 and stays set until reset_n=0. With MIG_BRIDGE_PERF_EN defined, hold app_rdy=0 for 7 cycles under app_en=1 → cmd_stall_cycles=7.
